// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: datapath width, truth
// constants and the alucode encodings produced by the decoder.
package alu_pkg;

   localparam int   XLEN  = 32;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_SLT  = 5'd2,
      ALU_SLTU = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_OR   = 5'd5,
      ALU_AND  = 5'd6,
      ALU_SLL  = 5'd7,
      ALU_SRL  = 5'd8,
      ALU_SRA  = 5'd9,
      ALU_LUI  = 5'd10,
      ALU_JAL  = 5'd11,
      ALU_JALR = 5'd12,
      ALU_BEQ  = 5'd13,
      ALU_BNE  = 5'd14,
      ALU_BLT  = 5'd15,
      ALU_BGE  = 5'd16,
      ALU_BLTU = 5'd17,
      ALU_BGEU = 5'd18,
      ALU_NOP  = 5'd19
   } alucode_e;

   // Link value written by JAL/JALR.
   function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational half of the ALU: operand muxes, result and branch condition.
// Branch compares always use r1/r2 directly, independent of the operand muxes.
module alu_comb
   import alu_pkg::*;
(
   input  logic [4:0]      alucode,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic            using_r2,
   input  logic            using_pc,
   output logic [XLEN-1:0] result,
   output logic            br_taken
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      shamt;
   logic            eq_r;
   logic            lt_s_r;
   logic            lt_u_r;

   assign op_a   = using_pc ? pc : r1;
   assign op_b   = using_r2 ? r2 : imm;
   assign shamt  = op_b[4:0];
   assign eq_r   = (r1 == r2);
   assign lt_s_r = ($signed(r1) < $signed(r2));
   assign lt_u_r = (r1 < r2);

   always_comb begin
      result   = '0;
      br_taken = FALSE;
      case (alucode)
         ALU_ADD:  result = op_a + op_b;
         ALU_SUB:  result = op_a - op_b;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, op_a < op_b};
         ALU_XOR:  result = op_a ^ op_b;
         ALU_OR:   result = op_a | op_b;
         ALU_AND:  result = op_a & op_b;
         ALU_SLL:  result = op_a << shamt;
         ALU_SRL:  result = op_a >> shamt;
         ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
         ALU_LUI:  result = op_b;
         ALU_JAL, ALU_JALR: begin
            result   = link_addr(pc);
            br_taken = TRUE;
         end
         ALU_BEQ:  br_taken = eq_r;
         ALU_BNE:  br_taken = !eq_r;
         ALU_BLT:  br_taken = lt_s_r;
         ALU_BGE:  br_taken = !lt_s_r;
         ALU_BLTU: br_taken = lt_u_r;
         ALU_BGEU: br_taken = !lt_u_r;
         // NOP and unassigned codes fall through with zeroed outputs.
         default: begin
            result   = '0;
            br_taken = FALSE;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU top: registers the combinational result and branch
// condition, giving one cycle of latency, with synchronous active-low reset.
module alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      alucode,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic            using_r2,
   input  logic            using_pc,
   output logic [XLEN-1:0] alu_result,
   output logic            br_taken
);

   logic [XLEN-1:0] comb_result;
   logic            comb_br;
   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic            br_taken_d, br_taken_q;

   alu_comb u_comb (
      .alucode  (alucode),
      .r1       (r1),
      .r2       (r2),
      .pc       (pc),
      .imm      (imm),
      .using_r2 (using_r2),
      .using_pc (using_pc),
      .result   (comb_result),
      .br_taken (comb_br)
   );

   always_comb begin
      alu_result_d = comb_result;
      br_taken_d   = comb_br;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_result_q <= '0;
         br_taken_q   <= FALSE;
      end else begin
         alu_result_q <= alu_result_d;
         br_taken_q   <= br_taken_d;
      end
   end

   assign alu_result = alu_result_q;
   assign br_taken   = br_taken_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with fixed expected values,
// then random operations checked against an arithmetic reference model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  alucode;
   logic [31:0] r1, r2, pc, imm;
   logic        using_r2, using_pc;
   logic [31:0] alu_result;
   logic        br_taken;

   int total = 0;
   int bad   = 0;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alucode    (alucode),
      .r1         (r1),
      .r2         (r2),
      .pc         (pc),
      .imm        (imm),
      .using_r2   (using_r2),
      .using_pc   (using_pc),
      .alu_result (alu_result),
      .br_taken   (br_taken)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%h want=%h", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the capturing edge.
   task automatic step(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic ur2, input logic upc);
      @(negedge clk);
      alucode = c; r1 = a; r2 = b; pc = p; imm = i; using_r2 = ur2; using_pc = upc;
      @(posedge clk);
      #1;
   endtask

   task automatic rr(input string tag, input logic [4:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input logic exp_br);
      step(c, a, b, 32'h0, 32'h0, 1'b1, 1'b0);
      check({tag, ".res"}, alu_result, exp_res);
      check({tag, ".br"}, {31'b0, br_taken}, {31'b0, exp_br});
   endtask

   // Reference model written from the operation definitions using wide
   // integer arithmetic rather than shift/compare operators on 32-bit values.
   function automatic void model(input logic [4:0] c, input logic [31:0] a_r1, input logic [31:0] b_r2,
                                 input logic [31:0] p, input logic [31:0] i, input logic ur2, input logic upc,
                                 output logic [31:0] res, output logic br);
      longint ua, ub, sa, sb, s1, s2, u1, u2, pow;
      int sh;
      ua = upc ? longint'(p) : longint'(a_r1);
      ub = ur2 ? longint'(b_r2) : longint'(i);
      sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
      sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
      u1 = longint'(a_r1);
      u2 = longint'(b_r2);
      s1 = (u1 >= 64'sd2147483648) ? u1 - 64'sd4294967296 : u1;
      s2 = (u2 >= 64'sd2147483648) ? u2 - 64'sd4294967296 : u2;
      sh  = int'(ub % 32);
      pow = 64'sd1;
      for (int k = 0; k < sh; k++) pow = pow * 2;
      res = 32'h0;
      br  = 1'b0;
      case (c)
         5'd0:  res = 32'((ua + ub) % 64'sd4294967296);
         5'd1:  res = 32'((ua + 64'sd4294967296 - ub) % 64'sd4294967296);
         5'd2:  res = (sa < sb) ? 32'd1 : 32'd0;
         5'd3:  res = (ua < ub) ? 32'd1 : 32'd0;
         5'd4:  res = 32'(ua) ^ 32'(ub);
         5'd5:  res = 32'(ua) | 32'(ub);
         5'd6:  res = 32'(ua) & 32'(ub);
         5'd7:  res = 32'((ua * pow) % 64'sd4294967296);
         5'd8:  res = 32'(ua / pow);
         5'd9:  begin
            // floor division of the signed value, wrapped back to 32 bits
            if (sa >= 0) res = 32'(sa / pow);
            else         res = 32'(((sa - pow + 1) / pow) + 64'sd4294967296);
         end
         5'd10: res = 32'(ub);
         5'd11, 5'd12: begin res = 32'((longint'(p) + 4) % 64'sd4294967296); br = 1'b1; end
         5'd13: br = (u1 == u2);
         5'd14: br = (u1 != u2);
         5'd15: br = (s1 < s2);
         5'd16: br = (s1 >= s2);
         5'd17: br = (u1 < u2);
         5'd18: br = (u1 >= u2);
         default: ;
      endcase
   endfunction

   initial begin
      logic [31:0] er;
      logic        eb;
      logic [4:0]  c;
      logic [31:0] a, b, p, i;
      logic        ur2, upc;

      rst_n = 1'b0; alucode = 5'd19; r1 = '0; r2 = '0; pc = '0; imm = '0;
      using_r2 = 1'b1; using_pc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.res", alu_result, 32'h0);
      check("rst.br", {31'b0, br_taken}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      rr("add",   5'd0,  32'd34,        32'd55,        32'd89,        1'b0);
      rr("sub",   5'd1,  32'd55,        32'd56,        32'hFFFFFFFF,  1'b0);
      rr("slt",   5'd2,  32'hFEEDFACE,  32'hBADCAB1E,  32'h0,         1'b0);
      rr("sltu",  5'd3,  32'hBADCAB1E,  32'hFEEDFACE,  32'h1,         1'b0);
      rr("xor",   5'd4,  32'hBADCAB1F,  32'hFEEDFACE,  32'h443151D1,  1'b0);
      rr("or",    5'd5,  32'hBADCAB1E,  32'hFEEDFACE,  32'hFEFDFBDE,  1'b0);
      rr("and",   5'd6,  32'hBADCAB1E,  32'hFEEDFACE,  32'hBACCAA0E,  1'b0);
      rr("sll",   5'd7,  32'hFEEDFACE,  32'd1036,      32'hDFACE000,  1'b0);
      rr("srl",   5'd8,  32'hDEADDEAD,  32'd16,        32'h0000DEAD,  1'b0);
      rr("sra",   5'd9,  32'hDEADDEAD,  32'd16,        32'hFFFFDEAD,  1'b0);
      rr("sh0",   5'd9,  32'h80000001,  32'd0,         32'h80000001,  1'b0);
      rr("sra31", 5'd9,  32'h80000000,  32'd31,        32'hFFFFFFFF,  1'b0);
      rr("ovf",   5'd0,  32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0);
      rr("wrap",  5'd1,  32'd0,         32'd1,         32'hFFFFFFFF,  1'b0);
      rr("sltb",  5'd2,  32'h80000000,  32'h7FFFFFFF,  32'h1,         1'b0);
      rr("sltub", 5'd3,  32'h80000000,  32'h7FFFFFFF,  32'h0,         1'b0);
      rr("beq",   5'd13, 32'd5,         32'd5,         32'h0,         1'b1);
      rr("bne",   5'd14, 32'd5,         32'd5,         32'h0,         1'b0);
      rr("blt",   5'd15, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b1);
      rr("bltu",  5'd17, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b0);
      rr("undef", 5'd31, 32'd7,         32'd9,         32'h0,         1'b0);

      step(5'd0, 32'hDEAD0000, 32'h5555, 32'h100, 32'h20, 1'b0, 1'b1);
      check("mux.add", alu_result, 32'h120);
      step(5'd11, 32'h0, 32'h0, 32'h100, 32'h0, 1'b1, 1'b0);
      check("jal.res", alu_result, 32'h104);
      check("jal.br", {31'b0, br_taken}, 32'h1);
      // branch compare must ignore the operand muxes
      step(5'd13, 32'd7, 32'd7, 32'd1, 32'd2, 1'b0, 1'b1);
      check("beqmux.br", {31'b0, br_taken}, 32'h1);

      // mid-stream reset wins over the op, then the op appears one edge later
      @(negedge clk);
      rst_n = 1'b0;
      alucode = 5'd0; r1 = 32'd1; r2 = 32'd1; using_r2 = 1'b1; using_pc = 1'b0;
      @(posedge clk); #1;
      check("rsthold.res", alu_result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rstrel.res", alu_result, 32'h2);

      for (int n = 0; n < 400; n++) begin
         c   = 5'($urandom_range(0, 31));
         a   = $urandom;
         b   = (n % 4 == 0) ? a : $urandom;
         p   = $urandom;
         i   = $urandom;
         ur2 = 1'($urandom_range(0, 1));
         upc = 1'($urandom_range(0, 1));
         step(c, a, b, p, i, ur2, upc);
         model(c, a, b, p, i, ur2, upc, er, eb);
         check($sformatf("rnd%0d.c%0d.res", n, c), alu_result, er);
         check($sformatf("rnd%0d.c%0d.br", n, c), {31'b0, br_taken}, {31'b0, eb});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
